// File: rtl/apb_packet_master.sv
// APB write master: sends a token-id write (0x20) then N payload word writes (0x24) per packet.
// Optional pready timeout with err_o is enabled by defining APB_PACKET_MASTER_TIMEOUT_EN.
module apb_packet_master #(
    parameter int unsigned BUS_AW            = 6,
    parameter int unsigned BUS_DW            = 32,
    parameter int unsigned MAX_CHANNEL_NUM   = 128,
    parameter int unsigned TOKEN_TABLE_ENTRY = 32,
    parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 pkt_valid_i,
    output logic                                 pkt_ready_o,
    input  logic [$clog2(TOKEN_TABLE_ENTRY)-1:0] pkt_token_id_i,
    input  logic [$clog2(MAX_CHANNEL_NUM)-1:0]   pkt_channel_num_i,
    input  logic                                 word_valid_i,
    input  logic [BUS_DW-1:0]                    word_data_i,
    output logic                                 word_ready_o,
    output logic [BUS_AW-1:0]                    m_paddr_o,
    output logic                                 m_pwrite_o,
    output logic                                 m_psel_o,
    output logic                                 m_penable_o,
    output logic [BUS_DW-1:0]                    m_pwdata_o,
    input  logic                                 m_pready_i,
    input  logic [BUS_DW-1:0]                    m_prdata_i,
`ifdef APB_PACKET_MASTER_TIMEOUT_EN
    output logic                                 err_o,
`endif
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int unsigned CntW = $clog2(MAX_CHANNEL_NUM);
    localparam logic [BUS_AW-1:0] TokAddr  = BUS_AW'(6'h20);
    localparam logic [BUS_AW-1:0] WordAddr = BUS_AW'(6'h24);

    typedef enum logic [2:0] {
        StIdle,
        StTokSetup,
        StTokAccess,
        StWordWait,
        StWordSetup,
        StWordAccess,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CntW-1:0]     chan_q, chan_d;
    logic [BUS_AW-1:0]   paddr_q, paddr_d;
    logic [BUS_DW-1:0]   pwdata_q, pwdata_d;
    logic                timeout_hit;
    logic                err_d;

    // Read data is never consumed: the master only issues writes.
    logic unused_prdata;
    assign unused_prdata = ^m_prdata_i;

`ifdef APB_PACKET_MASTER_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           err_q;
    logic           in_access;

    assign in_access   = (state_q == StTokAccess) || (state_q == StWordAccess);
    // Counts stalled ACCESS cycles; the TIMEOUT_CYCLES-th stalled cycle aborts the packet.
    assign timeout_hit = in_access && !m_pready_i && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = '0;
        if (in_access && !m_pready_i) begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0) ^ err_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            chan_q   <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            chan_q   <= chan_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        chan_d   = chan_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pkt_valid_i) begin
                    chan_d   = pkt_channel_num_i;
                    paddr_d  = TokAddr;
                    pwdata_d = BUS_DW'(pkt_token_id_i);
                    state_d  = StTokSetup;
                end
            end
            StTokSetup: state_d = StTokAccess;
            StTokAccess: begin
                if (m_pready_i) begin
                    cnt_d   = chan_q;
                    state_d = StWordWait;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StWordWait: begin
                if (word_valid_i) begin
                    paddr_d  = WordAddr;
                    pwdata_d = word_data_i;
                    state_d  = StWordSetup;
                end
            end
            StWordSetup: state_d = StWordAccess;
            StWordAccess: begin
                if (m_pready_i) begin
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q - CntW'(1);
                        state_d = StWordWait;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_psel_o    = 1'b0;
        m_penable_o = 1'b0;
        unique case (state_q)
            StTokSetup, StWordSetup: m_psel_o = 1'b1;
            StTokAccess, StWordAccess: begin
                m_psel_o    = 1'b1;
                m_penable_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign m_pwrite_o   = m_psel_o;
    assign m_paddr_o    = paddr_q;
    assign m_pwdata_o   = pwdata_q;
    assign pkt_ready_o  = (state_q == StIdle);
    assign word_ready_o = (state_q == StWordWait);
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);

endmodule
